// File: rtl/fetch_seq.sv
// Instruction-fetch sequencer: PC, req/ack word fetch, IR load strobe, redirect.
// Optional REQ timeout with sticky error when FETCH_TIMEOUT_EN is defined.
module fetch_seq #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [7:0]  TIMEOUT  = 8'd64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] ir_d,
  output logic        ir_ce,
  output logic [31:0] pc,
  output logic        busy,
  output logic        fetch_err
);

`ifdef FETCH_TIMEOUT_EN
  typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;
`else
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
`endif

  state_t      state, state_n;
  logic [31:0] pc_n, addr_n, ird_n;
  logic        req_n, ce_n;

`ifdef FETCH_TIMEOUT_EN
  logic [7:0] cnt, cnt_n;
  logic       err_n;
`endif

  assign busy = (state != IDLE);

  always_comb begin
    state_n = state;
    pc_n    = pc;
    addr_n  = mem_addr;
    req_n   = mem_req;
    ird_n   = ir_d;
    ce_n    = 1'b0;
`ifdef FETCH_TIMEOUT_EN
    cnt_n   = cnt;
    err_n   = fetch_err;
`endif
    // Redirect overrides everything, including an ack arriving in the same cycle.
    if (redirect) begin
      state_n = IDLE;
      pc_n    = {redirect_pc[31:2], 2'b00};
      req_n   = 1'b0;
`ifdef FETCH_TIMEOUT_EN
      err_n   = 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (!stall) begin
            state_n = REQ;
            req_n   = 1'b1;
            addr_n  = pc;
`ifdef FETCH_TIMEOUT_EN
            cnt_n   = '0;
`endif
          end
        end
        REQ: begin
          if (mem_ack) begin
            state_n = DONE;
            ird_n   = mem_rdata;
            ce_n    = 1'b1;
            pc_n    = pc + 32'd4;
            req_n   = 1'b0;
          end
`ifdef FETCH_TIMEOUT_EN
          else if (cnt + 8'd1 == TIMEOUT) begin
            state_n = ERR;
            req_n   = 1'b0;
            err_n   = 1'b1;
          end else begin
            cnt_n = cnt + 8'd1;
          end
`endif
        end
        DONE: state_n = IDLE;
        default: state_n = state;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      mem_addr <= RESET_PC;
      mem_req  <= 1'b0;
      ir_d     <= '0;
      ir_ce    <= 1'b0;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      mem_addr <= addr_n;
      mem_req  <= req_n;
      ir_d     <= ird_n;
      ir_ce    <= ce_n;
    end
  end

`ifdef FETCH_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      fetch_err <= 1'b0;
    end else begin
      cnt       <= cnt_n;
      fetch_err <= err_n;
    end
  end
`else
  assign fetch_err = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_seq.sv
// Directed bench for fetch_seq; second instance exercises PC wrap from FFFF_FFFC.
module tb_fetch_seq;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0, redirect = 1'b0, mem_ack = 1'b0;
  logic [31:0] redirect_pc = '0, mem_rdata = '0;
  logic        mem_req, ir_ce, busy, fetch_err;
  logic [31:0] mem_addr, ir_d, pc;

  logic        stall2 = 1'b1, ack2 = 1'b0;
  logic        req2, ce2, busy2, err2;
  logic [31:0] addr2, ird2, pc2;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  fetch_seq #(.RESET_PC(32'h0000_0000), .TIMEOUT(8'd4)) dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .ir_d(ir_d), .ir_ce(ir_ce), .pc(pc), .busy(busy), .fetch_err(fetch_err)
  );

  fetch_seq #(.RESET_PC(32'hFFFF_FFFC), .TIMEOUT(8'd64)) dut_wrap (
    .clk(clk), .rst(rst), .stall(stall2), .redirect(1'b0), .redirect_pc(32'h0),
    .mem_req(req2), .mem_addr(addr2), .mem_ack(ack2), .mem_rdata(32'hA5A5_0001),
    .ir_d(ird2), .ir_ce(ce2), .pc(pc2), .busy(busy2), .fetch_err(err2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    stall = 1'b0;
    #2;
    vectors++;
    if ({mem_req, ir_ce, busy, fetch_err} !== 4'b0000 || pc !== 32'h0 || mem_addr !== 32'h0 || ir_d !== 32'h0) begin
      $display("FAIL reset: req/ce/busy/err=%b pc=%h addr=%h ir_d=%h, want 0000 0 0 0",
               {mem_req, ir_ce, busy, fetch_err}, pc, mem_addr, ir_d);
      miscompares++;
    end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_single_fetch();
    tick();
    vectors++;
    if ({mem_req, busy, ir_ce} !== 3'b110 || mem_addr !== 32'h0) begin
      $display("FAIL single_req: req/busy/ce=%b addr=%h, want 110 0", {mem_req, busy, ir_ce}, mem_addr);
      miscompares++;
    end
    tick();
    mem_ack = 1'b1; mem_rdata = 32'h2002_0005;
    tick();
    mem_ack = 1'b0; mem_rdata = '0;
    vectors++;
    if ({mem_req, ir_ce} !== 2'b01 || ir_d !== 32'h2002_0005 || pc !== 32'h4) begin
      $display("FAIL single_load: req/ce=%b ir_d=%h pc=%h, want 01 20020005 4", {mem_req, ir_ce}, ir_d, pc);
      miscompares++;
    end
    stall = 1'b1;
    tick();
    vectors++;
    if ({ir_ce, busy} !== 2'b00) begin
      $display("FAIL single_done: ce/busy=%b, want 00", {ir_ce, busy});
      miscompares++;
    end
  endtask

  task automatic test_back_to_back();
    pulse_reset();
    stall = 1'b0; mem_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mem_rdata = 32'h1000_0000 + 32'(i);
      tick();
      vectors++;
      if (mem_req !== 1'b1 || mem_addr !== 32'(4 * i)) begin
        $display("FAIL b2b_req%0d: req=%b addr=%h, want 1 %h", i, mem_req, mem_addr, 32'(4 * i));
        miscompares++;
      end
      tick();
      vectors++;
      if (ir_ce !== 1'b1 || ir_d !== 32'h1000_0000 + 32'(i) || pc !== 32'(4 * i + 4)) begin
        $display("FAIL b2b_load%0d: ce=%b ir_d=%h pc=%h, want 1 %h %h", i, ir_ce, ir_d, pc,
                 32'h1000_0000 + 32'(i), 32'(4 * i + 4));
        miscompares++;
      end
      if (i == 3) stall = 1'b1;
      tick();
      vectors++;
      if ({ir_ce, mem_req, busy} !== 3'b000) begin
        $display("FAIL b2b_idle%0d: ce/req/busy=%b, want 000", i, {ir_ce, mem_req, busy});
        miscompares++;
      end
    end
    mem_ack = 1'b0;
  endtask

  task automatic test_redirect();
    stall = 1'b0;
    tick();
    vectors++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h10) begin
      $display("FAIL redir_pre: req=%b addr=%h, want 1 00000010", mem_req, mem_addr);
      miscompares++;
    end
    redirect = 1'b1; redirect_pc = 32'h0000_0103; mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    tick();
    redirect = 1'b0; mem_ack = 1'b0;
    vectors++;
    if ({mem_req, ir_ce, busy} !== 3'b000 || pc !== 32'h100) begin
      $display("FAIL redir_req: req/ce/busy=%b pc=%h, want 000 00000100", {mem_req, ir_ce, busy}, pc);
      miscompares++;
    end
    tick();
    vectors++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h100 || ir_ce !== 1'b0) begin
      $display("FAIL redir_next: req=%b addr=%h ce=%b, want 1 00000100 0", mem_req, mem_addr, ir_ce);
      miscompares++;
    end
    mem_ack = 1'b1; mem_rdata = 32'h0BAD_F00D;
    tick();
    mem_ack = 1'b0;
    redirect = 1'b1; redirect_pc = 32'h0000_0200; stall = 1'b1;
    vectors++;
    if (ir_ce !== 1'b1 || pc !== 32'h104) begin
      $display("FAIL redir_load: ce=%b pc=%h, want 1 00000104", ir_ce, pc);
      miscompares++;
    end
    tick();
    redirect = 1'b0;
    vectors++;
    if ({ir_ce, busy, mem_req} !== 3'b000 || pc !== 32'h200) begin
      $display("FAIL redir_done: ce/busy/req=%b pc=%h, want 000 00000200", {ir_ce, busy, mem_req}, pc);
      miscompares++;
    end
  endtask

  task automatic test_wrap();
    pulse_reset();
    vectors++;
    if (pc2 !== 32'hFFFF_FFFC || addr2 !== 32'hFFFF_FFFC || req2 !== 1'b0) begin
      $display("FAIL wrap_reset: pc=%h addr=%h req=%b, want fffffffc fffffffc 0", pc2, addr2, req2);
      miscompares++;
    end
    stall2 = 1'b0;
    tick();
    ack2 = 1'b1;
    tick();
    ack2 = 1'b0;
    vectors++;
    if (ce2 !== 1'b1 || pc2 !== 32'h0 || ird2 !== 32'hA5A5_0001) begin
      $display("FAIL wrap_load: ce=%b pc=%h ir_d=%h, want 1 0 a5a50001", ce2, pc2, ird2);
      miscompares++;
    end
    tick();
    tick();
    stall2 = 1'b1;
    vectors++;
    if (req2 !== 1'b1 || addr2 !== 32'h0) begin
      $display("FAIL wrap_next: req=%b addr=%h, want 1 0", req2, addr2);
      miscompares++;
    end
  endtask

  task automatic test_stall_and_reset();
    stall = 1'b1;
    pulse_reset();
    for (int i = 0; i < 10; i++) begin
      mem_ack = (i % 3 == 1);
      tick();
      vectors++;
      if ({mem_req, busy, ir_ce} !== 3'b000 || pc !== 32'h0) begin
        $display("FAIL stall%0d: req/busy/ce=%b pc=%h, want 000 0", i, {mem_req, busy, ir_ce}, pc);
        miscompares++;
      end
    end
    mem_ack = 1'b0; stall = 1'b0;
    tick();
    vectors++;
    if (mem_req !== 1'b1) begin
      $display("FAIL unstall: req=%b, want 1", mem_req);
      miscompares++;
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({mem_req, busy} !== 2'b00 || pc !== 32'h0) begin
      $display("FAIL async_rst: req/busy=%b pc=%h, want 00 0", {mem_req, busy}, pc);
      miscompares++;
    end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_timeout();
    for (int i = 1; i <= 4; i++) begin
      tick();
      vectors++;
      if ({mem_req, fetch_err} !== 2'b10) begin
        $display("FAIL to_wait%0d: req/err=%b, want 10", i, {mem_req, fetch_err});
        miscompares++;
      end
    end
    tick();
`ifdef FETCH_TIMEOUT_EN
    vectors++;
    if ({mem_req, fetch_err, busy} !== 3'b011) begin
      $display("FAIL to_err: req/err/busy=%b, want 011", {mem_req, fetch_err, busy});
      miscompares++;
    end
    stall = 1'b1;
    tick();
    vectors++;
    if ({mem_req, fetch_err} !== 2'b01) begin
      $display("FAIL to_hold: req/err=%b, want 01", {mem_req, fetch_err});
      miscompares++;
    end
    redirect = 1'b1; redirect_pc = 32'h0000_0040; stall = 1'b0;
    tick();
    redirect = 1'b0;
    vectors++;
    if ({fetch_err, busy} !== 2'b00 || pc !== 32'h40) begin
      $display("FAIL to_clear: err/busy=%b pc=%h, want 00 00000040", {fetch_err, busy}, pc);
      miscompares++;
    end
    tick();
    vectors++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h40) begin
      $display("FAIL to_refetch: req=%b addr=%h, want 1 00000040", mem_req, mem_addr);
      miscompares++;
    end
`else
    for (int i = 0; i < 6; i++) begin
      tick();
      vectors++;
      if ({mem_req, fetch_err, busy} !== 3'b101) begin
        $display("FAIL no_to%0d: req/err/busy=%b, want 101", i, {mem_req, fetch_err, busy});
        miscompares++;
      end
    end
`endif
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_back_to_back();
    test_redirect();
    test_wrap();
    test_stall_and_reset();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
